// File: rtl/ysyx_25040101_lsu.sv
// ysyx_25040101_lsu: load/store unit issuing one aligned word-bus access per request
module ysyx_25040101_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        read_1B_mem_en_i,
    input  logic        read_2B_mem_en_i,
    input  logic        read_2B_sext_mem_en_i,
    input  logic        read_4B_mem_en_i,
    input  logic        write_1B_mem_en_i,
    input  logic        write_2B_mem_en_i,
    input  logic        write_4B_mem_en_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_wen_o,
    output logic [3:0]  mem_wmask_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_resp_valid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_resp_ready_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [6:0]  en_q, en_d, en_in;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] shifted, load_data;
    logic        misaligned;
    // enable order: {sw, sh, sb, lw, lh, lhu, lbu}
    assign en_in = {write_4B_mem_en_i, write_2B_mem_en_i, write_1B_mem_en_i, read_4B_mem_en_i,
                    read_2B_sext_mem_en_i, read_2B_mem_en_i, read_1B_mem_en_i};
    assign misaligned = ((en_in[1] | en_in[2] | en_in[5]) & addr_i[0])
                      | ((en_in[3] | en_in[6]) & (|addr_i[1:0]));
    assign shifted = mem_rdata_i >> {addr_q[1:0], 3'b000};
    assign load_data = en_q[0] ? {24'b0, shifted[7:0]} :
                       en_q[1] ? {16'b0, shifted[15:0]} :
                       en_q[2] ? {{16{shifted[15]}}, shifted[15:0]} :
                       en_q[3] ? mem_rdata_i : 32'b0;
    // state and captured access registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            en_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
    // next-state: accept/classify, bus handshake, response wait with timeout, writeback handshake
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        en_d    = en_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid_i) begin
                addr_d  = addr_i;
                wdata_d = wdata_i;
                en_d    = en_in;
                rdata_d = '0;
                err_d   = ($countones(en_in) > 1) || misaligned;
                state_d = (err_d || en_in == '0) ? RESP : REQ;
            end
            REQ: if (mem_req_ready_i) begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: if (mem_resp_valid_i) begin
                rdata_d = load_data;
                err_d   = 1'b0;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_d == 8'(TIMEOUT_CYCLES)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: state_d = resp_ready_i ? IDLE : RESP;
        endcase
    end
    // outputs decoded from state, forced quiet during reset
    always_comb begin
        req_ready_o      = !rst && state_q == IDLE;
        resp_valid_o     = !rst && state_q == RESP;
        rdata_o          = resp_valid_o ? rdata_q : 32'b0;
        err_o            = resp_valid_o && err_q;
        mem_req_valid_o  = !rst && state_q == REQ;
        mem_resp_ready_o = rst || state_q == IDLE || state_q == WAIT;
        mem_addr_o       = mem_req_valid_o ? {addr_q[31:2], 2'b00} : 32'b0;
        mem_wen_o        = mem_req_valid_o && (|en_q[6:4]);
        mem_wmask_o      = !mem_req_valid_o ? 4'b0000 :
                           en_q[4] ? 4'b0001 << addr_q[1:0] :
                           en_q[5] ? 4'b0011 << addr_q[1:0] :
                           en_q[6] ? 4'b1111 : 4'b0000;
        mem_wdata_o      = !mem_req_valid_o ? 32'b0 :
                           en_q[4] ? {4{wdata_q[7:0]}} :
                           en_q[5] ? {2{wdata_q[15:0]}} :
                           en_q[6] ? wdata_q : 32'b0;
    end
endmodule

// File: doc/ysyx_25040101_lsu.md
Name: ysyx_25040101_lsu

Overview:
- Load/store unit; consumes the decoder's memory-enable strobes (read_1B/2B/2B_sext/4B, write_1B/2B/4B), plus ALU address and rs2 data.
- Executes one access on a word-addressed valid/ready data bus.
- Returns an aligned, extended load result (or store completion) to the writeback stage through a valid/ready response.
- Sits between EXU and the data memory/bus; one outstanding access at a time.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in WAIT before the access is aborted with err_o=1 (counter width 8 bits; legal 1..255).

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid_i  input  1  EXU presents an access
req_ready_o  output  1  LSU can accept (high only in IDLE)
addr_i  input  32  byte address from ALU
wdata_i  input  32  store data (rs2)
read_1B_mem_en_i  input  1  lbu
read_2B_mem_en_i  input  1  lhu
read_2B_sext_mem_en_i  input  1  lh
read_4B_mem_en_i  input  1  lw
write_1B_mem_en_i  input  1  sb
write_2B_mem_en_i  input  1  sh
write_4B_mem_en_i  input  1  sw
resp_valid_o  output  1  result available
resp_ready_i  input  1  writeback accepts result
rdata_o  output  32  extended load data; 0 for stores/errors
err_o  output  1  misaligned / multi-enable / timeout (qualified by resp_valid_o)
mem_req_valid_o  output  1  bus request
mem_req_ready_i  input  1  bus accepts request
mem_addr_o  output  32  {addr[31:2],2'b00}
mem_wen_o  output  1  1=write
mem_wmask_o  output  4  byte lane strobes
mem_wdata_o  output  32  lane-positioned write data
mem_resp_valid_i  input  1  bus response
mem_rdata_i  input  32  bus read word
mem_resp_ready_o  output  1  LSU accepts response

Behaviour:
- States IDLE, REQ, WAIT, RESP. Reset (any cycle, mid-access included) -> IDLE next edge; all outputs 0 during reset except mem_resp_ready_o=1; req_ready_o=1 from first IDLE cycle. Abandoned accesses are not resumed; stray bus responses are sunk.
- IDLE: req_ready_o=1, mem_resp_ready_o=1 (stray responses discarded). On req_valid_i, capture addr, wdata, enables (registered; inputs may change afterwards).
  - >1 enable set -> RESP, err=1.
  - 0 enables -> RESP, err=0, rdata 0 (no-op).
  - Misaligned (2B with addr[0]=1; 4B with addr[1:0]!=0) -> RESP, err=1, no bus access.
  - Otherwise -> REQ.
- REQ: mem_req_valid_o=1; addr/wen/wmask/wdata stable until mem_req_ready_i. On handshake -> WAIT, clear timeout counter. No timeout in REQ.
- Write mask / data:
  - sb: mask 4'b0001<<addr[1:0], data {4{wdata[7:0]}}.
  - sh: mask 4'b0011<<addr[1:0], data {2{wdata[15:0]}}.
  - sw: mask 4'b1111, data wdata.
  - Reads: wen=0, mask 4'b0000.
- WAIT: mem_resp_ready_o=1. On mem_resp_valid_i: latch result -> RESP, err=0. Counter increments each WAIT cycle without response; reaching TIMEOUT_CYCLES -> RESP, err=1, rdata 0. A response on the same cycle the counter reaches the limit wins (err=0).
- Load extraction: shifted = mem_rdata_i >> (addr[1:0]*8).
  - lbu: {24'b0,shifted[7:0]}
  - lhu: {16'b0,shifted[15:0]}
  - lh: {{16{shifted[15]}},shifted[15:0]}
  - lw: mem_rdata_i
  - Stores return rdata 0.
- RESP: resp_valid_o=1, rdata_o/err_o stable until resp_ready_i; on handshake -> IDLE. Next request is accepted no earlier than the cycle after the handshake.
- Latency: min 3 cycles from accept to resp_valid_o for a zero-wait bus (accept, REQ, WAIT, RESP). Error and no-op responses assert resp_valid_o the cycle after accept.

Test Plan:
- lh addr=0x8000_0002, bus word 0x8001_1234, zero-wait -> mem_addr_o=0x8000_0000, mask 0, rdata_o=0xFFFF_8001, err 0, resp_valid_o 3 cycles after accept.
- sb addr=0x100003, wdata=0xAB -> mem_wen_o=1, mem_wmask_o=4'b1000, mem_wdata_o=0xABAB_ABAB, then resp rdata 0, err 0.
- lw addr=0x102 -> no mem_req_valid_o ever, resp_valid_o next cycle with err_o=1; sh addr=0x101 same result.
- mem_req_ready_i low 5 cycles -> request fields stable all 5 cycles; mem_resp_valid_i never -> err_o=1 exactly TIMEOUT_CYCLES cycles after entering WAIT; a late response in IDLE is ignored.
- resp_ready_i low 4 cycles -> rdata_o/err_o held, req_ready_o=0 until the handshake; read_1B and write_4B set together -> err_o=1, no bus access.
- rst pulsed while in WAIT -> IDLE next cycle, mem_req_valid_o=0, resp_valid_o=0; new lbu addr 0x3, word 0xDE00_0000 -> rdata_o=0x0000_00DE.
